// File: rtl/riscv_decode_stage.sv
// Registered RISC-V decode stage: {instr, pc} from fetch in, decoded fields and control out to execute.
// Latency: 1 cycle from accept to out_valid; a single decoded instruction is held at a time.
// Backpressure: in_ready drops while the held result is stalled by out_ready=0 and during flush.
module riscv_decode_stage #(
    parameter int XLEN      = 32,
    parameter int REG_ADDRW = 3,
    parameter int EXT_OPS   = 0,
    parameter int ILL_CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [31:0]          in_instr,
    input  logic [XLEN-1:0]      in_pc,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [XLEN-1:0]      out_pc,
    output logic [REG_ADDRW-1:0] out_rs1,
    output logic [REG_ADDRW-1:0] out_rs2,
    output logic [REG_ADDRW-1:0] out_rd,
    output logic [XLEN-1:0]      out_imm,
    output logic [2:0]           out_alu_op,
    output logic                 out_alu_src_imm,
    output logic [1:0]           out_wb_sel,
    output logic [1:0]           out_pc_sel,
    output logic                 out_mem_we,
    output logic [2:0]           out_instr_type,
    output logic                 out_illegal,
    output logic [ILL_CNT_W-1:0] ill_count
);
    typedef enum logic [2:0] {
        ALU_ADD = 3'd0, ALU_SUB = 3'd1, ALU_PASS = 3'd2, ALU_AND = 3'd3,
        ALU_OR  = 3'd4, ALU_XOR = 3'd5, ALU_SLT  = 3'd6
    } alu_op_t;
    typedef enum logic [1:0] {WB_NONE = 2'd0, WB_ALU = 2'd1, WB_MEM = 2'd2, WB_PC4 = 2'd3} wb_sel_t;
    typedef enum logic [1:0] {PC_PLUS_4 = 2'd0, PC_BRANCH = 2'd1, PC_JUMP = 2'd2} pc_sel_t;
    typedef enum logic [2:0] {
        INSTR_R = 3'd0, INSTR_I = 3'd1, INSTR_S = 3'd2, INSTR_B = 3'd3, INSTR_J = 3'd4
    } instr_type_t;

    typedef struct packed {
        logic [XLEN-1:0]      pc;
        logic [REG_ADDRW-1:0] rs1;
        logic [REG_ADDRW-1:0] rs2;
        logic [REG_ADDRW-1:0] rd;
        logic [XLEN-1:0]      imm;
        alu_op_t              alu_op;
        logic                 alu_src_imm;
        wb_sel_t              wb_sel;
        pc_sel_t              pc_sel;
        logic                 mem_we;
        instr_type_t          instr_type;
        logic                 illegal;
    } dec_t;

    localparam logic [6:0] OPC_OP     = 7'h33;
    localparam logic [6:0] OPC_OP_IMM = 7'h13;
    localparam logic [6:0] OPC_LOAD   = 7'h03;
    localparam logic [6:0] OPC_STORE  = 7'h23;
    localparam logic [6:0] OPC_BRANCH = 7'h63;
    localparam logic [6:0] OPC_JAL    = 7'h6f;
    localparam bit         EXT        = (EXT_OPS != 0);

    logic [6:0]      opcode, funct7;
    logic [2:0]      funct3;
    logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_j;
    logic            ext_ok, legal, bad_reg;
    logic            use_rs1, use_rs2, use_rd;
    alu_op_t         ext_op;
    dec_t            dec, dec_q;
    logic            accept;

    assign opcode = in_instr[6:0];
    assign funct3 = in_instr[14:12];
    assign funct7 = in_instr[31:25];
    assign imm_i  = {{(XLEN-12){in_instr[31]}}, in_instr[31:20]};
    assign imm_s  = {{(XLEN-12){in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
    assign imm_b  = {{(XLEN-12){in_instr[31]}}, in_instr[7], in_instr[30:25], in_instr[11:8], 1'b0};
    assign imm_j  = {{(XLEN-20){in_instr[31]}}, in_instr[19:12], in_instr[20], in_instr[30:21], 1'b0};

    always_comb begin
        ext_ok = 1'b1;
        ext_op = ALU_ADD;
        case (funct3)
            3'b111:  ext_op = ALU_AND;
            3'b110:  ext_op = ALU_OR;
            3'b100:  ext_op = ALU_XOR;
            3'b010:  ext_op = ALU_SLT;
            default: ext_ok = 1'b0;
        endcase
    end

    always_comb begin
        dec     = '0;
        dec.pc  = in_pc;
        legal   = 1'b0;
        use_rs1 = 1'b0;
        use_rs2 = 1'b0;
        use_rd  = 1'b0;
        case (opcode)
            OPC_OP: begin
                {use_rs1, use_rs2, use_rd} = 3'b111;
                dec.instr_type = INSTR_R;
                dec.wb_sel     = WB_ALU;
                if (funct3 == 3'b000 && funct7 == 7'h00) begin
                    legal = 1'b1; dec.alu_op = ALU_ADD;
                end else if (funct3 == 3'b000 && funct7 == 7'h20) begin
                    legal = 1'b1; dec.alu_op = ALU_SUB;
                end else if (EXT && funct7 == 7'h00 && ext_ok) begin
                    legal = 1'b1; dec.alu_op = ext_op;
                end
            end
            OPC_OP_IMM: begin
                {use_rs1, use_rd} = 2'b11;
                dec.instr_type  = INSTR_I;
                dec.imm         = imm_i;
                dec.alu_src_imm = 1'b1;
                dec.wb_sel      = WB_ALU;
                if (funct3 == 3'b000) begin
                    legal = 1'b1; dec.alu_op = ALU_ADD;
                end else if (EXT && ext_ok) begin
                    legal = 1'b1; dec.alu_op = ext_op;
                end
            end
            OPC_LOAD: begin
                {use_rs1, use_rd} = 2'b11;
                legal           = (funct3 == 3'b010);
                dec.instr_type  = INSTR_I;
                dec.imm         = imm_i;
                dec.alu_src_imm = 1'b1;
                dec.wb_sel      = WB_MEM;
            end
            OPC_STORE: begin
                {use_rs1, use_rs2} = 2'b11;
                legal           = (funct3 == 3'b010);
                dec.instr_type  = INSTR_S;
                dec.imm         = imm_s;
                dec.alu_src_imm = 1'b1;
                dec.mem_we      = 1'b1;
            end
            OPC_BRANCH: begin
                {use_rs1, use_rs2} = 2'b11;
                legal          = (funct3 == 3'b000);
                dec.instr_type = INSTR_B;
                dec.imm        = imm_b;
                dec.alu_op     = ALU_SUB;
                dec.pc_sel     = PC_BRANCH;
            end
            OPC_JAL: begin
                use_rd         = 1'b1;
                legal          = 1'b1;
                dec.instr_type = INSTR_J;
                dec.imm        = imm_j;
                dec.alu_op     = ALU_PASS;
                dec.pc_sel     = PC_JUMP;
                dec.wb_sel     = WB_PC4;
            end
            default: ;
        endcase

        // Only the register fields an instruction actually uses must fit in REG_ADDRW bits.
        bad_reg = (use_rs1 && (in_instr[19:15] >> REG_ADDRW) != 5'd0)
               || (use_rs2 && (in_instr[24:20] >> REG_ADDRW) != 5'd0)
               || (use_rd  && (in_instr[11:7]  >> REG_ADDRW) != 5'd0);

        if (!legal || bad_reg) begin
            dec         = '0;
            dec.pc      = in_pc;
            dec.illegal = 1'b1;
        end else begin
            dec.rs1 = use_rs1 ? in_instr[15 +: REG_ADDRW] : '0;
            dec.rs2 = use_rs2 ? in_instr[20 +: REG_ADDRW] : '0;
            dec.rd  = use_rd  ? in_instr[7  +: REG_ADDRW] : '0;
            if (dec.rd == '0)
                dec.wb_sel = WB_NONE;
        end
    end

    assign in_ready = !flush && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            dec_q     <= '0;
            ill_count <= '0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (accept) begin
            out_valid <= 1'b1;
            dec_q     <= dec;
            if (dec.illegal && ill_count != '1)
                ill_count <= ill_count + ILL_CNT_W'(1);
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

    assign out_pc          = dec_q.pc;
    assign out_rs1         = dec_q.rs1;
    assign out_rs2         = dec_q.rs2;
    assign out_rd          = dec_q.rd;
    assign out_imm         = dec_q.imm;
    assign out_alu_op      = dec_q.alu_op;
    assign out_alu_src_imm = dec_q.alu_src_imm;
    assign out_wb_sel      = dec_q.wb_sel;
    assign out_pc_sel      = dec_q.pc_sel;
    assign out_mem_we      = dec_q.mem_we;
    assign out_instr_type  = dec_q.instr_type;
    assign out_illegal     = dec_q.illegal;
endmodule

// File: tb/tb_riscv_decode_stage.sv
// Bench for riscv_decode_stage: base instance plus an EXT_OPS=1 / ILL_CNT_W=2 instance fed the same stream,
// both checked against a cycle-level reference of the handshake and an instruction-table decode model.
module tb_riscv_decode_stage;
    localparam logic [2:0] A_ADD = 3'd0, A_SUB = 3'd1, A_PASS = 3'd2, A_AND = 3'd3,
                           A_OR  = 3'd4, A_XOR = 3'd5, A_SLT  = 3'd6;
    localparam logic [1:0] W_NONE = 2'd0, W_ALU = 2'd1, W_MEM = 2'd2, W_PC4 = 2'd3;
    localparam logic [1:0] P_PLUS4 = 2'd0, P_BRANCH = 2'd1, P_JUMP = 2'd2;
    localparam logic [2:0] T_R = 3'd0, T_I = 3'd1, T_S = 3'd2, T_B = 3'd3, T_J = 3'd4;

    localparam logic [31:0] I_ADD  = 32'h002081B3;
    localparam logic [31:0] I_SW   = 32'h0020A423;
    localparam logic [31:0] I_ADDI = 32'hFFF00093;
    localparam logic [31:0] I_LUI  = 32'h000010B7;
    localparam logic [31:0] I_ADD9 = 32'h004004B3;

    typedef struct packed {
        logic [31:0] pc;
        logic [2:0]  rs1, rs2, rd;
        logic [31:0] imm;
        logic [2:0]  alu;
        logic        src;
        logic [1:0]  wb, pcs;
        logic        we;
        logic [2:0]  typ;
        logic        ill;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst, flush, in_valid, out_ready;
    logic [31:0] in_instr, in_pc;

    logic        a_in_ready, a_out_valid, a_src, a_we, a_ill;
    logic [31:0] a_pc, a_imm;
    logic [2:0]  a_rs1, a_rs2, a_rd, a_alu, a_typ;
    logic [1:0]  a_wb, a_pcs;
    logic [15:0] a_cnt;
    logic        b_in_ready, b_out_valid, b_src, b_we, b_ill;
    logic [31:0] b_pc, b_imm;
    logic [2:0]  b_rs1, b_rs2, b_rd, b_alu, b_typ;
    logic [1:0]  b_wb, b_pcs;
    logic [1:0]  b_cnt;

    int   checks = 0, errors = 0;
    bit   m_valid;
    exp_t m_a, m_b;
    int   m_cnt_a, m_cnt_b;

    always #5 clk = ~clk;

    riscv_decode_stage u_dut (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(a_in_ready),
        .in_instr(in_instr), .in_pc(in_pc), .out_valid(a_out_valid), .out_ready(out_ready),
        .out_pc(a_pc), .out_rs1(a_rs1), .out_rs2(a_rs2), .out_rd(a_rd), .out_imm(a_imm),
        .out_alu_op(a_alu), .out_alu_src_imm(a_src), .out_wb_sel(a_wb), .out_pc_sel(a_pcs),
        .out_mem_we(a_we), .out_instr_type(a_typ), .out_illegal(a_ill), .ill_count(a_cnt)
    );

    riscv_decode_stage #(.EXT_OPS(1), .ILL_CNT_W(2)) u_dut_ext (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(b_in_ready),
        .in_instr(in_instr), .in_pc(in_pc), .out_valid(b_out_valid), .out_ready(out_ready),
        .out_pc(b_pc), .out_rs1(b_rs1), .out_rs2(b_rs2), .out_rd(b_rd), .out_imm(b_imm),
        .out_alu_op(b_alu), .out_alu_src_imm(b_src), .out_wb_sel(b_wb), .out_pc_sel(b_pcs),
        .out_mem_we(b_we), .out_instr_type(b_typ), .out_illegal(b_ill), .ill_count(b_cnt)
    );

    function automatic logic [31:0] sext(input logic [31:0] v, input int bits);
        logic [31:0] s;
        s = 32'd1 << (bits - 1);
        return (v ^ s) - s;
    endfunction

    // Instruction-table model; illegal words only define pc/rd/wb/pc_sel/mem_we/illegal.
    function automatic exp_t model(input logic [31:0] w, input bit ext);
        exp_t e;
        int   op, f3, f7, r1, r2, rd;
        bit   ok, u1, u2, ud, ext_f3;
        e = '0; ok = 0; u1 = 0; u2 = 0; ud = 0;
        op = int'(w[6:0]); f3 = int'(w[14:12]); f7 = int'(w[31:25]);
        r1 = int'(w[19:15]); r2 = int'(w[24:20]); rd = int'(w[11:7]);
        ext_f3 = ext && (f3 == 7 || f3 == 6 || f3 == 4 || f3 == 2);
        case (op)
            'h33: begin
                u1 = 1; u2 = 1; ud = 1; e.typ = T_R; e.wb = W_ALU;
                if (f3 == 0 && f7 == 0) begin ok = 1; e.alu = A_ADD; end
                else if (f3 == 0 && f7 == 32) begin ok = 1; e.alu = A_SUB; end
                else if (ext_f3 && f7 == 0) ok = 1;
            end
            'h13: begin
                u1 = 1; ud = 1; e.typ = T_I; e.wb = W_ALU; e.src = 1; e.imm = sext(32'(w[31:20]), 12);
                ok = (f3 == 0) || ext_f3;
            end
            'h03: begin
                u1 = 1; ud = 1; e.typ = T_I; e.wb = W_MEM; e.src = 1; e.imm = sext(32'(w[31:20]), 12);
                ok = (f3 == 2);
            end
            'h23: begin
                u1 = 1; u2 = 1; e.typ = T_S; e.src = 1; e.we = 1;
                e.imm = sext(32'({w[31:25], w[11:7]}), 12);
                ok = (f3 == 2);
            end
            'h63: begin
                u1 = 1; u2 = 1; e.typ = T_B; e.alu = A_SUB; e.pcs = P_BRANCH;
                e.imm = sext(32'({w[31], w[7], w[30:25], w[11:8], 1'b0}), 13);
                ok = (f3 == 0);
            end
            'h6f: begin
                ud = 1; ok = 1; e.typ = T_J; e.alu = A_PASS; e.pcs = P_JUMP; e.wb = W_PC4;
                e.imm = sext(32'({w[31], w[19:12], w[20], w[30:21], 1'b0}), 21);
            end
            default: ok = 0;
        endcase
        if (ok && e.typ inside {T_R, T_I} && op != 'h03 && f3 != 0)
            e.alu = (f3 == 7) ? A_AND : (f3 == 6) ? A_OR : (f3 == 4) ? A_XOR : A_SLT;
        if ((u1 && r1 >= 8) || (u2 && r2 >= 8) || (ud && rd >= 8)) ok = 0;
        if (!ok) begin
            e = '0;
            e.ill = 1;
            return e;
        end
        if (u1) e.rs1 = 3'(r1);
        if (u2) e.rs2 = 3'(r2);
        if (ud) e.rd = 3'(rd);
        if (ud && rd == 0) e.wb = W_NONE;
        return e;
    endfunction

    function automatic exp_t obs_a();
        exp_t o;
        o = {a_pc, a_rs1, a_rs2, a_rd, a_imm, a_alu, a_src, a_wb, a_pcs, a_we, a_typ, a_ill};
        if (o.ill) begin o.rs1 = '0; o.rs2 = '0; o.imm = '0; o.alu = '0; o.src = '0; o.typ = '0; end
        return o;
    endfunction

    function automatic exp_t obs_b();
        exp_t o;
        o = {b_pc, b_rs1, b_rs2, b_rd, b_imm, b_alu, b_src, b_wb, b_pcs, b_we, b_typ, b_ill};
        if (o.ill) begin o.rs1 = '0; o.rs2 = '0; o.imm = '0; o.alu = '0; o.src = '0; o.typ = '0; end
        return o;
    endfunction

    // Advance the reference by one clock using the inputs currently driven, then step the DUT.
    task automatic tick();
        if (rst) begin
            m_valid = 0; m_a = '0; m_b = '0; m_cnt_a = 0; m_cnt_b = 0;
        end else if (flush) begin
            m_valid = 0;
        end else if (in_valid && (!m_valid || out_ready)) begin
            m_valid = 1;
            m_a = model(in_instr, 0); m_a.pc = in_pc;
            m_b = model(in_instr, 1); m_b.pc = in_pc;
            if (m_a.ill && m_cnt_a < 65535) m_cnt_a++;
            if (m_b.ill && m_cnt_b < 3) m_cnt_b++;
        end else if (m_valid && out_ready) begin
            m_valid = 0;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1; flush = 0; in_valid = 0; out_ready = 1; in_instr = '0; in_pc = '0;
        tick(); tick();
        checks++; if (a_out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", a_out_valid); end
        checks++; if (a_in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", a_in_ready); end
        checks++; if (a_cnt !== 16'd0) begin errors++; $display("FAIL reset_ill_count got %0d want 0", a_cnt); end
        checks++; if (a_wb !== W_NONE) begin errors++; $display("FAIL reset_wb_sel got %0d want %0d", a_wb, W_NONE); end
        checks++; if (b_cnt !== 2'd0) begin errors++; $display("FAIL reset_ill_count_ext got %0d want 0", b_cnt); end
        rst = 0;
    endtask

    task automatic test_add_store();
        in_valid = 1; out_ready = 1; in_instr = I_ADD; in_pc = 32'h100;
        tick();
        in_instr = I_SW; in_pc = 32'h104;
        checks++;
        if (a_out_valid !== 1 || a_rs1 !== 3'd1 || a_rs2 !== 3'd2 || a_rd !== 3'd3 || a_alu !== A_ADD
            || a_wb !== W_ALU || a_imm !== 32'd0 || a_pc !== 32'h100) begin
            errors++; $display("FAIL add_fields got v=%b rs1=%0d rs2=%0d rd=%0d alu=%0d wb=%0d imm=%h want 1/1/2/3/0/1/0",
                                a_out_valid, a_rs1, a_rs2, a_rd, a_alu, a_wb, a_imm);
        end
        checks++; if (obs_a() !== m_a) begin errors++; $display("FAIL add_model got %h want %h", obs_a(), m_a); end
        tick();
        in_valid = 0;
        checks++;
        if (a_out_valid !== 1 || a_imm !== 32'd8 || a_we !== 1 || a_rd !== 3'd0 || a_wb !== W_NONE || a_src !== 1) begin
            errors++; $display("FAIL sw_fields got v=%b imm=%h we=%b rd=%0d wb=%0d want 1/8/1/0/0", a_out_valid, a_imm, a_we, a_rd, a_wb);
        end
        checks++; if (obs_b() !== m_b) begin errors++; $display("FAIL sw_model_ext got %h want %h", obs_b(), m_b); end
        tick();
        checks++; if (a_out_valid !== 0) begin errors++; $display("FAIL drain_valid got %b want 0", a_out_valid); end
    endtask

    task automatic test_addi();
        in_valid = 1; in_instr = I_ADDI; in_pc = 32'h200;
        tick();
        in_valid = 0;
        checks++;
        if (a_imm !== 32'hFFFFFFFF || a_src !== 1 || a_rd !== 3'd1 || a_wb !== W_ALU || a_typ !== T_I) begin
            errors++; $display("FAIL addi_fields got imm=%h src=%b rd=%0d wb=%0d want ffffffff/1/1/1", a_imm, a_src, a_rd, a_wb);
        end
        tick();
    endtask

    task automatic test_backpressure();
        exp_t held;
        in_valid = 1; out_ready = 0; in_instr = I_ADD; in_pc = 32'h300;
        tick();
        held = model(I_ADD, 0); held.pc = 32'h300;
        in_instr = I_ADDI; in_pc = 32'h304;
        for (int i = 0; i < 5; i++) begin
            #1;
            checks++; if (a_in_ready !== 0) begin errors++; $display("FAIL stall_in_ready cyc%0d got %b want 0", i, a_in_ready); end
            checks++; if (a_out_valid !== 1 || obs_a() !== held) begin errors++; $display("FAIL stall_hold cyc%0d got %h want %h", i, obs_a(), held); end
            tick();
        end
        out_ready = 1;
        #1;
        checks++; if (a_in_ready !== 1) begin errors++; $display("FAIL release_in_ready got %b want 1", a_in_ready); end
        tick();
        in_valid = 0;
        checks++; if (a_out_valid !== 1 || a_pc !== 32'h304 || a_imm !== 32'hFFFFFFFF) begin
            errors++; $display("FAIL release_addi got v=%b pc=%h imm=%h want 1/304/ffffffff", a_out_valid, a_pc, a_imm); end
        tick();
        checks++; if (a_out_valid !== 0) begin errors++; $display("FAIL release_nodup got %b want 0", a_out_valid); end
    endtask

    task automatic test_illegal();
        rst = 1; tick(); rst = 0;
        in_valid = 1; out_ready = 1; in_instr = I_LUI; in_pc = 32'h400;
        tick();
        in_instr = I_ADD9; in_pc = 32'h404;
        tick();
        in_valid = 0;
        checks++; if (a_ill !== 1 || a_wb !== W_NONE || a_rd !== 3'd0 || a_we !== 0 || a_pcs !== P_PLUS4) begin
            errors++; $display("FAIL ill_fields got ill=%b wb=%0d rd=%0d we=%b pcs=%0d want 1/0/0/0/0", a_ill, a_wb, a_rd, a_we, a_pcs); end
        checks++; if (a_cnt !== 16'd2) begin errors++; $display("FAIL ill_count2 got %0d want 2", a_cnt); end
        checks++; if (b_cnt !== 2'd2) begin errors++; $display("FAIL ill_count2_ext got %0d want 2", b_cnt); end
        in_valid = 1;
        for (int i = 0; i < 3; i++) begin
            in_instr = I_LUI | (32'(i) << 12); tick();
        end
        in_valid = 0;
        checks++; if (a_cnt !== 16'd5) begin errors++; $display("FAIL ill_count5 got %0d want 5", a_cnt); end
        checks++; if (b_cnt !== 2'd3) begin errors++; $display("FAIL ill_count_sat got %0d want 3", b_cnt); end
        tick();
    endtask

    task automatic test_flush();
        int cnt_before;
        in_valid = 1; out_ready = 0; in_instr = I_ADD; in_pc = 32'h500;
        tick();
        cnt_before = int'(a_cnt);
        flush = 1; in_instr = I_LUI; in_pc = 32'h504;
        #1;
        checks++; if (a_in_ready !== 0) begin errors++; $display("FAIL flush_in_ready got %b want 0", a_in_ready); end
        tick();
        flush = 0; in_valid = 0;
        checks++; if (a_out_valid !== 0) begin errors++; $display("FAIL flush_valid got %b want 0", a_out_valid); end
        checks++; if (int'(a_cnt) !== cnt_before) begin errors++; $display("FAIL flush_count got %0d want %0d", a_cnt, cnt_before); end
        in_valid = 1; out_ready = 1;
        tick();
        in_valid = 0;
        checks++; if (a_out_valid !== 1 || a_ill !== 1 || a_pc !== 32'h504) begin
            errors++; $display("FAIL post_flush_accept got v=%b ill=%b pc=%h want 1/1/504", a_out_valid, a_ill, a_pc); end
        tick();
        checks++; if (a_out_valid !== 0 || int'(a_cnt) !== cnt_before + 1) begin
            errors++; $display("FAIL post_flush_once got v=%b cnt=%0d want 0/%0d", a_out_valid, a_cnt, cnt_before + 1); end
    endtask

    function automatic logic [31:0] gen_instr();
        logic [31:0] w;
        w = $urandom;
        case ($urandom_range(0, 9))
            0, 1:    w[6:0] = 7'h33;
            2, 9:    w[6:0] = 7'h13;
            3:       w[6:0] = 7'h03;
            4:       w[6:0] = 7'h23;
            5:       w[6:0] = 7'h63;
            6:       w[6:0] = 7'h6f;
            7:       w[6:0] = 7'h37;
            default: ;
        endcase
        case ($urandom_range(0, 2))
            0:       w[14:12] = 3'd0;
            1:       w[14:12] = 3'd2;
            default: ;
        endcase
        case ($urandom_range(0, 2))
            0:       w[31:25] = 7'h00;
            1:       w[31:25] = 7'h20;
            default: ;
        endcase
        if ($urandom_range(0, 3) != 0) w[19:18] = 2'b00;
        if ($urandom_range(0, 3) != 0) w[24:23] = 2'b00;
        if ($urandom_range(0, 3) != 0) w[11:10] = 2'b00;
        return w;
    endfunction

    task automatic test_random();
        bit exp_rdy;
        for (int i = 0; i < 3000; i++) begin
            rst       = ($urandom_range(0, 299) == 0);
            flush     = ($urandom_range(0, 11) == 0);
            in_valid  = ($urandom_range(0, 9) < 7);
            out_ready = ($urandom_range(0, 9) < 7);
            in_instr  = gen_instr();
            in_pc     = $urandom & 32'hFFFFFFFC;
            #1;
            exp_rdy = !flush && (!m_valid || out_ready);
            checks++; if (a_in_ready !== exp_rdy || b_in_ready !== exp_rdy) begin
                errors++; $display("FAIL rnd_in_ready cyc%0d got %b/%b want %b", i, a_in_ready, b_in_ready, exp_rdy); end
            checks++; if (a_out_valid !== m_valid || b_out_valid !== m_valid) begin
                errors++; $display("FAIL rnd_out_valid cyc%0d got %b/%b want %b", i, a_out_valid, b_out_valid, m_valid); end
            if (m_valid) begin
                checks++; if (obs_a() !== m_a) begin errors++; $display("FAIL rnd_dec cyc%0d got %h want %h", i, obs_a(), m_a); end
                checks++; if (obs_b() !== m_b) begin errors++; $display("FAIL rnd_dec_ext cyc%0d got %h want %h", i, obs_b(), m_b); end
            end
            checks++; if (int'(a_cnt) !== m_cnt_a || int'(b_cnt) !== m_cnt_b) begin
                errors++; $display("FAIL rnd_ill_count cyc%0d got %0d/%0d want %0d/%0d", i, a_cnt, b_cnt, m_cnt_a, m_cnt_b); end
            tick();
        end
        rst = 0; flush = 0; in_valid = 0;
    endtask

    initial begin
        test_reset();
        test_add_store();
        test_addi();
        test_backpressure();
        test_illegal();
        test_flush();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
